// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter over eight requesters feeding a registered 8:1 data mux
// with a valid/ready output handshake and a completed-transfer counter.
module mux_rr_arbiter #(
  parameter int unsigned NREQ  = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [WIDTH-1:0] In3,
  input  logic [WIDTH-1:0] In4,
  input  logic [WIDTH-1:0] In5,
  input  logic [WIDTH-1:0] In6,
  input  logic [WIDTH-1:0] In7,
  input  logic [WIDTH-1:0] In8,
  output logic [NREQ-1:0]  ack,
  output logic [2:0]       Sel,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      xfer_count
);

  localparam int unsigned SW = 3;
  localparam int unsigned CW = 16;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [SW-1:0]    r_ptr, w_ptr_nxt;
  logic [SW-1:0]    r_sel, w_sel_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic [NREQ-1:0]  r_ack, w_ack_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  logic [WIDTH-1:0] w_in [NREQ];
  logic             w_accept;
  logic [SW-1:0]    w_base;
  logic             w_found;
  logic [SW-1:0]    w_win;

  assign w_in[0] = In1;
  assign w_in[1] = In2;
  assign w_in[2] = In3;
  assign w_in[3] = In4;
  assign w_in[4] = In5;
  assign w_in[5] = In6;
  assign w_in[6] = In7;
  assign w_in[7] = In8;

  // Accepting a transfer moves the search start past the current winner in the same edge
  assign w_accept = (r_state == BUSY) && out_ready;
  assign w_base   = w_accept ? SW'(r_sel + SW'(1)) : r_ptr;

  // First set request in circular order starting at w_base
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      logic [SW-1:0] v_idx;
      v_idx = SW'(w_base + SW'(k));
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_out_nxt   = r_out;
    w_ack_nxt   = '0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_sel_nxt   = w_win;
          w_out_nxt   = w_in[w_win];
          w_ack_nxt   = NREQ'(1) << w_win;
        end
      end
      BUSY: begin
        if (out_ready) begin
          w_ptr_nxt = SW'(r_sel + SW'(1));
          w_cnt_nxt = CW'(r_cnt + CW'(1));
          if (w_found) begin
            w_sel_nxt = w_win;
            w_out_nxt = w_in[w_win];
            w_ack_nxt = NREQ'(1) << w_win;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_out   <= '0;
      r_ack   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_out   <= w_out_nxt;
      r_ack   <= w_ack_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign ack        = r_ack;
  assign Sel        = r_sel;
  assign Out        = r_out;
  assign out_valid  = (r_state == BUSY);
  assign xfer_count = r_cnt;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus random traffic, each cycle
// compared against a transaction-level round-robin model.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din [8];
  logic [7:0] ack;
  logic [2:0] Sel;
  logic [7:0] Out;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] xfer_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit         m_valid;
  int         m_sel;
  logic [7:0] m_out;
  int         m_ptr;
  int         m_cnt;
  logic [7:0] m_ack;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.NREQ(8), .WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .In1        (din[0]),
    .In2        (din[1]),
    .In3        (din[2]),
    .In4        (din[3]),
    .In5        (din[4]),
    .In6        (din[5]),
    .In7        (din[6]),
    .In8        (din[7]),
    .ack        (ack),
    .Sel        (Sel),
    .Out        (Out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict from the inputs presented at the edge, then compare
  task automatic step();
    bit         n_valid = m_valid;
    int         n_sel   = m_sel;
    logic [7:0] n_out   = m_out;
    int         n_ptr   = m_ptr;
    int         n_cnt   = m_cnt;
    logic [7:0] n_ack   = 8'h00;
    if (!rst_n) begin
      n_valid = 0; n_sel = 0; n_out = 8'h00; n_ptr = 0; n_cnt = 0;
    end else begin
      bit take = m_valid && out_ready;
      int start = take ? (m_sel + 1) % 8 : m_ptr;
      if (take) begin
        n_ptr = (m_sel + 1) % 8;
        n_cnt = (m_cnt + 1) % 65536;
      end
      if (!m_valid || take) begin
        if (req != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            int w = (start + k) % 8;
            if (req[w] && n_ack == 8'h00) begin
              n_sel   = w;
              n_out   = din[w];
              n_valid = 1;
              n_ack   = 8'h01 << w;
            end
          end
        end else begin
          n_valid = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_sel = n_sel; m_out = n_out;
    m_ptr = n_ptr; m_cnt = n_cnt; m_ack = n_ack;
    check("model_valid", 32'(out_valid), 32'(m_valid));
    check("model_ack", 32'(ack), 32'(m_ack));
    check("model_cnt", 32'(xfer_count), 32'(m_cnt));
    if (m_valid) begin
      check("model_sel", 32'(Sel), 32'(m_sel));
      check("model_out", 32'(Out), 32'(m_out));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_index_data();
    for (int i = 0; i < 8; i++) din[i] = 8'(i);
  endtask

  initial begin
    int ack5;
    rst_n = 1'b0; req = 8'h00; out_ready = 1'b0;
    set_index_data();
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sel", 32'(Sel), 32'd0);
    check("rst_out", 32'(Out), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_cnt", 32'(xfer_count), 32'd0);

    // Full-request sweep: one transfer per cycle, Sel walks 0..7,0
    req = 8'hFF; out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      check("sweep_sel", 32'(Sel), 32'(j % 8));
      check("sweep_out", 32'(Out), 32'(j % 8));
      check("sweep_cnt", 32'(xfer_count), 32'(j));
    end

    // Wrap-around search from ptr=3
    do_reset();
    req = 8'h04; out_ready = 1'b0;
    step();
    check("wrap_first", 32'(Sel), 32'd2);
    req = 8'h84; out_ready = 1'b1;
    step();
    check("wrap_sel7", 32'(Sel), 32'd7);
    check("wrap_out7", 32'(Out), 32'd7);
    step();
    check("wrap_sel2", 32'(Sel), 32'd2);

    // Stall: winner 5 held stable while inputs move
    do_reset();
    req = 8'h20; out_ready = 1'b0;
    step();
    ack5 = (ack == 8'h20) ? 1 : 0;
    din[5] = 8'hAA;
    for (int j = 0; j < 10; j++) begin
      req = 8'($urandom);
      step();
      if (ack != 8'h00) ack5++;
      check("stall_sel", 32'(Sel), 32'd5);
      check("stall_out", 32'(Out), 32'd5);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    check("stall_ack_pulses", 32'(ack5), 32'd1);
    din[5] = 8'd5;

    // No requests: everything idles; then a single-cycle request
    do_reset();
    req = 8'h00;
    for (int j = 0; j < 12; j++) begin
      out_ready = 1'($urandom);
      step();
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_ack", 32'(ack), 32'd0);
      check("idle_cnt", 32'(xfer_count), 32'd0);
    end
    req = 8'h10;
    step();
    req = 8'h00;
    check("single_sel", 32'(Sel), 32'd4);
    check("single_ack", 32'(ack), 32'h10);
    step();
    check("single_ack_gone", 32'(ack), 32'd0);

    // Reset mid-transfer discards the pending item and rewinds the pointer
    do_reset();
    req = 8'h08; out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sel", 32'(Sel), 32'd0);
    check("mid_rst_out", 32'(Out), 32'd0);
    check("mid_rst_cnt", 32'(xfer_count), 32'd0);
    req = 8'hFF;
    step();
    check("post_rst_sel", 32'(Sel), 32'd0);

    // Random traffic against the model
    for (int j = 0; j < 1500; j++) begin
      req = (($urandom % 4) == 0) ? 8'h00 : 8'($urandom & $urandom);
      for (int i = 0; i < 8; i++) din[i] = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      rst_n = ($urandom % 200) != 0;
      step();
    end
    rst_n = 1'b1;

    // Counter wrap at 0xFFFF
    set_index_data();
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int j = 0; j < 65536; j++) step();
    check("cnt_ffff", 32'(xfer_count), 32'h0000FFFF);
    step();
    check("cnt_wrap", 32'(xfer_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
